// File: rtl/mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: registered single-cycle multiply, restoring divider.
// Optional MDU_DIV_FAST_EN: divide-by-zero and signed overflow bypass the iteration loop.
module mdu_iter #(
  parameter int XLEN       = 32,
  parameter int DIV_UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] rd_o,
  output logic            busy_o,
  output logic [2:0]      dbg_state_o
);

  localparam int N_ITER = XLEN / DIV_UNROLL;
  localparam int CNT_W  = $clog2(N_ITER + 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_quot, r_dvsr, r_rem, r_rd;
  logic [2*XLEN-1:0] r_prod;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg_q, r_neg_r, r_fix_ph, r_valid;

  logic              w_accept, w_fast, w_s1, w_s2, w_a_sgn, w_b_sgn, w_ge;
  logic [XLEN-1:0]   w_mag1, w_mag2, w_quot_nxt, w_rem_nxt, w_sub, w_result;
  logic [XLEN:0]     w_shift;
  logic [2*XLEN-1:0] w_prod;

  // Handshakes: a request transfers on valid_i & ready_o & !flush_i; a result
  // transfers on valid_o & ready_i. ready_o depends on the state register only.
  assign ready_o     = (r_state == S_IDLE);
  assign busy_o      = (r_state != S_IDLE);
  assign valid_o     = r_valid;
  assign rd_o        = r_rd;
  assign dbg_state_o = r_state;
  assign w_accept    = valid_i & ready_o & ~flush_i;

  assign w_s1   = ~op_i[0] & rs1_i[XLEN-1];
  assign w_s2   = ~op_i[0] & rs2_i[XLEN-1];
  assign w_mag1 = w_s1 ? -rs1_i : rs1_i;
  assign w_mag2 = w_s2 ? -rs2_i : rs2_i;

`ifdef MDU_DIV_FAST_EN
  assign w_fast = op_i[2] & ((rs2_i == '0) |
                  (~op_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_i)));
`else
  assign w_fast = 1'b0;
`endif

  // Sign-extending to 2*XLEN makes the low 2*XLEN bits of an unsigned multiply exact.
  assign w_a_sgn = (r_op[1:0] != 2'b11) & r_quot[XLEN-1];
  assign w_b_sgn = ~r_op[1] & r_dvsr[XLEN-1];
  assign w_prod  = {{XLEN{w_a_sgn}}, r_quot} * {{XLEN{w_b_sgn}}, r_dvsr};

  always_comb begin
    w_rem_nxt  = r_rem;
    w_quot_nxt = r_quot;
    w_shift    = '0;
    w_ge       = 1'b0;
    w_sub      = '0;
    for (int i = 0; i < DIV_UNROLL; i++) begin
      w_shift    = {w_rem_nxt, w_quot_nxt[XLEN-1]};
      w_ge       = (w_shift >= {1'b0, r_dvsr});
      w_sub      = w_shift[XLEN-1:0] - r_dvsr;
      w_rem_nxt  = w_ge ? w_sub : w_shift[XLEN-1:0];
      w_quot_nxt = {w_quot_nxt[XLEN-2:0], w_ge};
    end
  end

  assign w_result = r_op[2] ? (r_op[1] ? r_rem : r_quot)
                            : ((r_op[1:0] == 2'b00) ? r_prod[XLEN-1:0] : r_prod[2*XLEN-1:XLEN]);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = op_i[2] ? (w_fast ? S_FIX : S_DIV) : S_MUL;
      S_MUL:  w_next = S_FIX;
      S_DIV:  if (r_cnt == CNT_W'(1)) w_next = S_FIX;
      S_FIX:  if (~r_op[2] | r_fix_ph) w_next = S_DONE;
      S_DONE: if (ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush_i && r_state != S_IDLE) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_quot   <= '0;
      r_dvsr   <= '0;
      r_rem    <= '0;
      r_rd     <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_fix_ph <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= (w_next == S_DONE);
      if (w_accept) begin
        r_op     <= op_i;
        r_fix_ph <= 1'b0;
        if (!op_i[2]) begin
          r_quot <= rs1_i;
          r_dvsr <= rs2_i;
        end else begin
          r_quot  <= w_mag1;
          r_dvsr  <= w_mag2;
          r_rem   <= '0;
          r_neg_q <= (w_s1 ^ w_s2) & (rs2_i != '0);
          r_neg_r <= w_s1;
          r_cnt   <= CNT_W'(N_ITER);
`ifdef MDU_DIV_FAST_EN
          if (w_fast) begin
            r_quot  <= (rs2_i == '0) ? '1 : rs1_i;
            r_rem   <= (rs2_i == '0) ? rs1_i : '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
          end
`endif
        end
      end else if (!flush_i) begin
        case (r_state)
          S_MUL: r_prod <= w_prod;
          S_DIV: begin
            r_quot <= w_quot_nxt;
            r_rem  <= w_rem_nxt;
            r_cnt  <= r_cnt - CNT_W'(1);
          end
          // Divides spend one FIX cycle on the sign correction, then one on the select.
          S_FIX: begin
            if (r_op[2] && !r_fix_ph) begin
              r_quot   <= r_neg_q ? -r_quot : r_quot;
              r_rem    <= r_neg_r ? -r_rem : r_rem;
              r_fix_ph <= 1'b1;
            end else begin
              r_rd <= w_result;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: a 32-bit/unroll-1 unit and a 64-bit/unroll-4 unit share stimulus.
module tb_mdu_iter;

`ifdef MDU_DIV_FAST_EN
  localparam int LAT_CORNER = 2;
`else
  localparam int LAT_CORNER = 34;
`endif

  logic        clk = 1'b0;
  logic        rst_n, valid_i, flush_i, ready_i;
  logic [2:0]  op_i;
  logic [63:0] rs1, rs2;

  logic        ready_a, valid_a, busy_a, ready_b, valid_b, busy_b;
  logic [31:0] rd_a;
  logic [63:0] rd_b;
  logic [2:0]  dbg_a, dbg_b;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  mdu_iter #(.XLEN(32), .DIV_UNROLL(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_a), .op_i(op_i),
    .rs1_i(rs1[31:0]), .rs2_i(rs2[31:0]), .flush_i(flush_i), .valid_o(valid_a),
    .ready_i(ready_i), .rd_o(rd_a), .busy_o(busy_a), .dbg_state_o(dbg_a)
  );

  mdu_iter #(.XLEN(64), .DIV_UNROLL(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_b), .op_i(op_i),
    .rs1_i(rs1), .rs2_i(rs2), .flush_i(flush_i), .valid_o(valid_b),
    .ready_i(ready_i), .rd_o(rd_b), .busy_o(busy_b), .dbg_state_o(dbg_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int c = 0; c < 100; c++) begin
      if (ready_a && ready_b) break;
      tick();
    end
    check("ready_wait", {63'b0, ready_a & ready_b}, 64'd1);
  endtask

  // Issue one request to both units and collect each result and its latency.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [31:0] exp_a, input int lat_a_exp,
                       input bit use_b, input logic [63:0] exp_b, input int lat_b_exp);
    logic [31:0] res_a, exp;
    logic [63:0] res_b;
    int          lat_a, lat_b;
    bit          got_a, got_b;
    wait_ready();
    op_i = op; rs1 = a; rs2 = b; valid_i = 1'b1;
    exp_q.push_back(exp_a);
    tick();
    valid_i = 1'b0;
    lat_a = 999; lat_b = 999; got_a = 0; got_b = 0; res_a = '0; res_b = '0;
    for (int c = 0; c < 80; c++) begin
      if (!got_a && valid_a) begin got_a = 1; lat_a = c; res_a = rd_a; end
      if (!got_b && valid_b) begin got_b = 1; lat_b = c; res_b = rd_b; end
      if (got_a && got_b) break;
      tick();
    end
    tick();
    exp = exp_q.pop_front();
    check(tag, {32'b0, res_a}, {32'b0, exp});
    check({tag, "_lat"}, 64'(lat_a), 64'(lat_a_exp));
    if (use_b) begin
      check({tag, "_x64"}, res_b, exp_b);
      check({tag, "_x64_lat"}, 64'(lat_b), 64'(lat_b_exp));
    end
    last_rd = exp;
  endtask

  initial begin
    int cyc, seen;
    rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    op_i = '0; rs1 = '0; rs2 = '0; last_rd = '0;
    repeat (2) tick();
    check("rst_ready", {63'b0, ready_a}, 64'd1);
    check("rst_valid", {63'b0, valid_a}, 64'd0);
    check("rst_busy", {63'b0, busy_a}, 64'd0);
    check("rst_rd", {32'b0, rd_a}, 64'd0);
    check("rst_state", {61'b0, dbg_a}, 64'd0);
    rst_n = 1'b1;
    tick();

    do_op("mul",    3'b000, 64'hFFFFFFFE, 64'd3, 32'hFFFFFFFA, 2, 0, 0, 0);
    do_op("mulh",   3'b001, 64'hFFFFFFFE, 64'd3, 32'hFFFFFFFF, 2, 0, 0, 0);
    do_op("mulhsu", 3'b010, 64'hFFFFFFFE, 64'd3, 32'hFFFFFFFF, 2, 0, 0, 0);
    do_op("mulhu",  3'b011, 64'hFFFFFFFE, 64'd3, 32'h00000002, 2, 0, 0, 0);

    do_op("div_m7_2",  3'b100, 64'hFFFFFFF9, 64'd2,    32'hFFFFFFFD, 34, 0, 0, 0);
    do_op("rem_m7_2",  3'b110, 64'hFFFFFFF9, 64'd2,    32'hFFFFFFFF, 34, 0, 0, 0);
    do_op("divu_big",  3'b101, 64'hFFFFFFFF, 64'h10,   32'h0FFFFFFF, 34, 0, 0, 0);
    do_op("remu_big",  3'b111, 64'hFFFFFFFF, 64'h10,   32'h0000000F, 34, 0, 0, 0);

    do_op("div_by0",   3'b100, 64'd5,        64'd0,        32'hFFFFFFFF, LAT_CORNER, 0, 0, 0);
    do_op("rem_by0",   3'b110, 64'd5,        64'd0,        32'h00000005, LAT_CORNER, 0, 0, 0);
    do_op("remn_by0",  3'b110, 64'hFFFFFFF9, 64'd0,        32'hFFFFFFF9, LAT_CORNER, 0, 0, 0);
    do_op("divu_by0",  3'b101, 64'd5,        64'd0,        32'hFFFFFFFF, LAT_CORNER, 0, 0, 0);
    do_op("div_ovf",   3'b100, 64'h80000000, 64'hFFFFFFFF, 32'h80000000, LAT_CORNER, 0, 0, 0);
    do_op("rem_ovf",   3'b110, 64'h80000000, 64'hFFFFFFFF, 32'h00000000, LAT_CORNER, 0, 0, 0);

    do_op("mulhu_ones", 3'b011, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
          32'hFFFFFFFE, 2, 1, 64'hFFFFFFFFFFFFFFFE, 2);
    do_op("div_100_7", 3'b100, 64'd100, 64'd7, 32'd14, 34, 1, 64'd14, 18);

    // Consumer back-pressure with a second request waiting at the input.
    wait_ready();
    ready_i = 1'b0; op_i = 3'b101; rs1 = 64'd100; rs2 = 64'd7; valid_i = 1'b1;
    exp_q.push_back(32'd14);
    tick();
    valid_i = 1'b0;
    cyc = 0;
    while (!valid_a && cyc < 60) begin tick(); cyc++; end
    check("bp_lat", 64'(cyc), 64'd34);
    check("bp_rd", {32'b0, rd_a}, {32'b0, exp_q.pop_front()});
    op_i = 3'b000; rs1 = 64'd3; rs2 = 64'd4; valid_i = 1'b1;
    repeat (5) begin
      tick();
      check("bp_hold_valid", {63'b0, valid_a}, 64'd1);
      check("bp_hold_rd", {32'b0, rd_a}, 64'd14);
      check("bp_hold_ready", {63'b0, ready_a}, 64'd0);
    end
    ready_i = 1'b1;
    tick();
    check("bp_taken_valid", {63'b0, valid_a}, 64'd0);
    check("bp_not_yet_accepted", {63'b0, busy_a}, 64'd0);
    tick();
    valid_i = 1'b0;
    check("bp_accepted", {63'b0, busy_a}, 64'd1);
    cyc = 0;
    while (!valid_a && cyc < 60) begin tick(); cyc++; end
    check("bp_mul_lat", 64'(cyc), 64'd2);
    check("bp_mul_rd", {32'b0, rd_a}, 64'hC);
    tick();

    do_op("divu_1000_3", 3'b101, 64'd1000, 64'd3, 32'd333, 34, 0, 0, 0);

    // Flush at the tenth divide iteration.
    wait_ready();
    op_i = 3'b100; rs1 = 64'd1000; rs2 = 64'd7; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_busy", {63'b0, busy_a}, 64'd0);
    check("flush_ready", {63'b0, ready_a}, 64'd1);
    check("flush_valid", {63'b0, valid_a}, 64'd0);
    check("flush_rd_kept", {32'b0, rd_a}, {32'b0, last_rd});
    seen = 0;
    repeat (40) begin tick(); if (valid_a) seen++; end
    check("flush_no_result", 64'(seen), 64'd0);
    do_op("mul_after_flush", 3'b000, 64'd3, 64'd4, 32'hC, 2, 0, 0, 0);

    // Flush beats a request presented in IDLE.
    op_i = 3'b000; rs1 = 64'd5; rs2 = 64'd5; valid_i = 1'b1; flush_i = 1'b1;
    tick();
    valid_i = 1'b0; flush_i = 1'b0;
    check("idle_flush_reject", {63'b0, busy_a}, 64'd0);

    // Asynchronous reset in the middle of a divide.
    wait_ready();
    op_i = 3'b100; rs1 = 64'd1000; rs2 = 64'd7; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {63'b0, ready_a}, 64'd1);
    check("mid_rst_busy", {63'b0, busy_a}, 64'd0);
    check("mid_rst_valid", {63'b0, valid_a}, 64'd0);
    check("mid_rst_rd", {32'b0, rd_a}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_op("mul_after_rst", 3'b000, 64'd7, 64'd6, 32'd42, 2, 1, 64'd42, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
